// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with a combinational ready chain,
// synchronous flush and a registered occupancy count.
module register_pipe #(
    parameter int unsigned      WIDTH       = 3,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d [DEPTH];
    logic [OCC_W-1:0] occ_nxt;

    // Ready chain runs from the output side back towards stage 0 so a full
    // pipe can still accept a beat in the same cycle the last stage drains.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            adv[DEPTH-1-i] = !v[DEPTH-i] || adv[DEPTH-i];
        end
        load = ~v | adv;
        in_ready = load[0] && !flush;
    end

    always_comb begin
        v_nxt = v;
        if (flush) begin
            v_nxt = '0;
        end else begin
            if (load[0]) v_nxt[0] = in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (load[i]) v_nxt[i] = v[i-1];
            end
        end
        occ_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            occupancy <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VALUE;
            end
        end else begin
            v         <= v_nxt;
            occupancy <= occ_nxt;
            // Flush discards beats by clearing valids only; data registers hold.
            if (!flush) begin
                if (load[0]) d[0] <= in_data;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    if (load[i]) d[i] <= d[i-1];
                end
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule
